// File: rtl/ssd_scan_mux.sv
// Multiplexed seven-segment scanner: one digit per DIV-clock slot, a blanked
// dead band at each slot start, and a 15-step PWM for brightness.
module ssd_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 125000,
    parameter int DEAD     = 64
) (
    input  logic                  clk125MHz,
    input  logic                  rst_n,
    input  logic [7*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [3:0]            bright,
    input  logic                  en,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [2:0]            scan_idx,
    output logic                  frame_tick
);

    localparam int              SW        = $clog2(DIV);
    localparam logic [SW-1:0]   SLOT_LAST = SW'(DIV - 1);
    localparam logic [SW-1:0]   DEAD_END  = SW'(DEAD);
    localparam logic [2:0]      IDX_LAST  = 3'(N_DIGITS - 1);
    localparam logic [3:0]      PWM_LAST  = 4'd14;
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    logic [SW-1:0]       r_slot_cnt;
    logic [2:0]          r_idx;
    logic [3:0]          r_pwm_cnt;
    logic [6:0]          r_lat_seg;
    logic                r_lat_dp;
    logic                r_lat_en;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_tick;

    logic                w_slot_wrap;
    logic                w_idx_wrap;
    logic                w_on;
    logic [6:0]          w_seg_slice [N_DIGITS];
    logic [N_DIGITS-1:0] w_an_on;
    logic [6:0]          w_sel_seg;
    logic                w_sel_dp;
    logic                w_sel_en;

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_idx_wrap  = (r_idx == IDX_LAST);

    // Per-digit segment slices and the one-hot-low anode pattern for r_idx.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign w_seg_slice[gi] = seg_in[7*gi +: 7];
            assign w_an_on[gi]     = (r_idx != 3'(gi));
        end
    endgenerate

    always_comb begin
        w_sel_seg = SEG_BLANK;
        w_sel_dp  = 1'b0;
        w_sel_en  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_sel_seg = w_seg_slice[i];
                w_sel_dp  = dp_in[i];
                w_sel_en  = digit_en[i];
            end
        end
    end

    // The dead band keeps the anodes off while the latched data and index settle.
    assign w_on = en && r_lat_en && (r_slot_cnt >= DEAD_END) && (r_pwm_cnt < bright);

    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_idx        <= 3'd0;
            r_pwm_cnt    <= 4'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
            r_pwm_cnt    <= (r_pwm_cnt == PWM_LAST) ? 4'd0 : r_pwm_cnt + 4'd1;
            r_frame_tick <= w_slot_wrap && w_idx_wrap;
            if (w_slot_wrap) begin
                r_idx <= w_idx_wrap ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    // Digit data is captured once per slot so mid-slot input changes cannot tear.
    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_seg <= SEG_BLANK;
            r_lat_dp  <= 1'b0;
            r_lat_en  <= 1'b0;
        end else if (r_slot_cnt == '0) begin
            r_lat_seg <= w_sel_seg;
            r_lat_dp  <= w_sel_dp;
            r_lat_en  <= w_sel_en;
        end
    end

    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_on) begin
            r_an  <= w_an_on;
            r_seg <= r_lat_seg;
            r_dp  <= ~r_lat_dp;
        end else begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign scan_idx   = r_idx;
    assign frame_tick = r_frame_tick;

endmodule
